operand_stage: RTL and testbench

OPERAND_STAGE -- requirements
Module: operand_stage

---
 rtl/operand_pkg.sv | 18 +
 rtl/imm_extender.sv | 34 +++
 rtl/operand_stage.sv | 95 +++++++++
 tb/tb_operand_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared encodings for the operand stage: operand-B extension modes and
// the output/skid buffer state machine.
package operand_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_REG   = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } stage_state_e;

endpackage

// File: rtl/imm_extender.sv
// Combinational operand-B builder: sign/zero/upper extension of the immediate
// or register bypass. Upper-load exists only with OPERAND_STAGE_UPPER_LOAD_EN.
module imm_extender
    import operand_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        ext_mode,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] op_b
);

    ext_mode_e mode;

    always_comb begin
        mode = ext_mode_e'(ext_mode);
        op_b = rt_data;
        case (mode)
            EXT_SIGN:  op_b = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
`ifdef OPERAND_STAGE_UPPER_LOAD_EN
            EXT_ZERO:  op_b = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_UPPER: op_b = {imm, {(DATA_W-IMM_W){1'b0}}};
`else
            // Without upper-load support mode 10 aliases zero-fill.
            EXT_ZERO,
            EXT_UPPER: op_b = {{(DATA_W-IMM_W){1'b0}}, imm};
`endif
            default:   op_b = rt_data;
        endcase
    end

endmodule

// File: rtl/operand_stage.sv
// Operand register stage with a one-entry skid buffer so in_ready depends only
// on registered state. Optional upper-load via OPERAND_STAGE_UPPER_LOAD_EN.
module operand_stage
    import operand_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        ext_mode,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b
);

    stage_state_e      state;
    logic [DATA_W-1:0] ext_b;
    logic [DATA_W-1:0] skid_a;
    logic [DATA_W-1:0] skid_b;
    logic              acc;
    logic              xfer;

    imm_extender #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_ext (
        .imm      (imm),
        .ext_mode (ext_mode),
        .rt_data  (rt_data),
        .op_b     (ext_b)
    );

    assign in_ready = (state != ST_SKID);
    assign acc      = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            skid_a    <= '0;
            skid_b    <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        op_a      <= rs_data;
                        op_b      <= ext_b;
                        out_valid <= 1'b1;
                        state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (acc && xfer) begin
                        op_a <= rs_data;
                        op_b <= ext_b;
                    end else if (acc) begin
                        // Output is stalled; park the new bundle behind it.
                        skid_a <= rs_data;
                        skid_b <= ext_b;
                        state  <= ST_SKID;
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (xfer) begin
                        op_a  <= skid_a;
                        op_b  <= skid_b;
                        state <= ST_FULL;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: table of single-bundle vectors plus
// hand-written stall, flush and mid-operation reset sequences.
module tb_operand_stage;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  imm;
    logic [1:0]        ext_mode;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    int n_chk  = 0;
    int n_fail = 0;

    operand_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .ext_mode  (ext_mode),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IMM_W-1:0]  imm;
        logic [1:0]        mode;
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rt;
        logic [DATA_W-1:0] exp_b;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IMM_W-1:0] i,
                         input logic [1:0] m, input logic [DATA_W-1:0] rs,
                         input logic [DATA_W-1:0] rt);
        in_valid = v;
        imm      = i;
        ext_mode = m;
        rs_data  = rs;
        rt_data  = rt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h8001, 2'b00, 32'h1111_1111, 32'h0, 32'hFFFF_8001};
        vecs[1] = '{16'h8001, 2'b01, 32'h2222_2222, 32'h0, 32'h0000_8001};
`ifdef OPERAND_STAGE_UPPER_LOAD_EN
        vecs[2] = '{16'h8001, 2'b10, 32'h3333_3333, 32'h0, 32'h8001_0000};
        vecs[6] = '{16'h0001, 2'b10, 32'h7777_7777, 32'h5, 32'h0001_0000};
`else
        vecs[2] = '{16'h8001, 2'b10, 32'h3333_3333, 32'h0, 32'h0000_8001};
        vecs[6] = '{16'h0001, 2'b10, 32'h7777_7777, 32'h5, 32'h0000_0001};
`endif
        vecs[3] = '{16'h8001, 2'b11, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{16'h7FFF, 2'b00, 32'h5555_5555, 32'h0, 32'h0000_7FFF};
        vecs[5] = '{16'hFFFF, 2'b00, 32'h6666_6666, 32'h0, 32'hFFFF_FFFF};
        vecs[7] = '{16'hABCD, 2'b11, 32'h8888_8888, 32'h0, 32'h0000_0000};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, 2'b00, '0, '0);
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single bundles with out_ready high: visible one cycle after accept.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, vecs[k].imm, vecs[k].mode, vecs[k].rs, vecs[k].rt);
            tick();
            drive(1'b0, '0, 2'b00, '0, '0);
            check($sformatf("vec%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("vec%0d_op_a", k), op_a, vecs[k].rs);
            check($sformatf("vec%0d_op_b", k), op_b, vecs[k].exp_b);
            tick();
        end
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // Stall: A, B accepted, C held off until output drains.
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 2'b00, 32'hA000_000A, '0);
        tick();
        drive(1'b1, 16'h0002, 2'b00, 32'hB000_000B, '0);
        tick();
        drive(1'b1, 16'h0003, 2'b00, 32'hC000_000C, '0);
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        check("stall_op_a_A", op_a, 32'hA000_000A);
        tick();
        check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
        check("stall_hold_op_a", op_a, 32'hA000_000A);
        check("stall_hold_op_b", op_b, 32'h0000_0001);
        out_ready = 1'b1;
        tick();
        check("drain_op_a_B", op_a, 32'hB000_000B);
        check("drain_op_b_B", op_b, 32'h0000_0002);
        check("drain_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b0, '0, 2'b00, '0, '0);
        check("drain_op_a_C", op_a, 32'hC000_000C);
        check("drain_valid_C", {31'b0, out_valid}, 32'd1);
        tick();
        check("drain_empty", {31'b0, out_valid}, 32'd0);

        // Flush while in SKID with a competing accept.
        out_ready = 1'b0;
        drive(1'b1, 16'h0010, 2'b01, 32'hD000_0001, '0);
        tick();
        drive(1'b1, 16'h0011, 2'b01, 32'hD000_0002, '0);
        tick();
        check("pre_flush_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 16'h0012, 2'b01, 32'hD000_0003, '0);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 2'b00, '0, '0);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("flush_no_emit", {31'b0, out_valid}, 32'd0);

        // Reset mid-operation while FULL.
        out_ready = 1'b0;
        drive(1'b1, 16'h00FF, 2'b00, 32'hE000_000E, '0);
        tick();
        drive(1'b0, '0, 2'b00, '0, '0);
        check("full_before_rst", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_op_a", op_a, 32'd0);
        check("midrst_op_b", op_b, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("post_rst_idle", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
